busy_table: RTL and testbench



---
 rtl/qu_common_pkg.sv | 24 ++
 rtl/busy_table_popcount.sv | 28 ++
 rtl/busy_table.sv | 95 +++++++++
 tb/tb_busy_table.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qu_common_pkg.sv
//==============================================================================
// Module      : qu_common (package)
// Description : Shared constants and types for the Qu out-of-order core.
//               Physical-register address type reused by map, issue,
//               writeback and the busy table.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package qu_common;

    // Default physical register file depth (power of two)
    localparam int QU_PHY_RF_DEPTH = 128;

    // Default number of writeback and issue-side lookup ports
    localparam int QU_NUM_WB_PORTS = 2;
    localparam int QU_NUM_RD_PORTS = 2;

    // Physical register index at the default depth
    typedef logic [$clog2(QU_PHY_RF_DEPTH)-1:0] phy_addr_t;

endpackage : qu_common

`default_nettype wire

// File: rtl/busy_table_popcount.sv
//==============================================================================
// Module      : popcount
// Description : Combinational population count of a WIDTH-bit vector.
//               Output is wide enough to hold WIDTH itself.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module popcount #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]       i_vec,
    output logic [$clog2(WIDTH):0] o_count
);

    localparam int c_cnt_w = $clog2(WIDTH) + 1;

    // Sum every bit of the input vector
    always_comb begin
        o_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_count = o_count + c_cnt_w'(i_vec[i]);
        end
    end

endmodule : popcount

`default_nettype wire

// File: rtl/busy_table.sv
//==============================================================================
// Module      : busy_table
// Description : Physical-register readiness scoreboard. Map marks a new
//               destination busy through the set port, writeback ports clear
//               it, and issue reads readiness combinationally with a bypass
//               of same-cycle clears. Entry 0 is permanently ready.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module busy_table
    import qu_common::*;
#(
    parameter int PHY_RF_DEPTH = QU_PHY_RF_DEPTH,
    parameter int NUM_WB_PORTS = QU_NUM_WB_PORTS,
    parameter int NUM_RD_PORTS = QU_NUM_RD_PORTS
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      flush,
    input  logic                                      set_en,
    input  logic [$clog2(PHY_RF_DEPTH)-1:0]           set_addr,
    input  logic                                      set_data,
    input  logic [NUM_WB_PORTS-1:0]                   clr_en,
    input  logic [NUM_WB_PORTS*$clog2(PHY_RF_DEPTH)-1:0] clr_addr,
    input  logic [NUM_RD_PORTS*$clog2(PHY_RF_DEPTH)-1:0] rd_addr,
    output logic [NUM_RD_PORTS-1:0]                   rd_busy,
    output logic [$clog2(PHY_RF_DEPTH):0]             busy_count
);

    localparam int c_aw = $clog2(PHY_RF_DEPTH);

    logic [PHY_RF_DEPTH-1:0] r_busy;
    logic [PHY_RF_DEPTH-1:0] w_busy_nxt;
    logic [PHY_RF_DEPTH-1:0] w_clr_hit;
    logic [c_aw:0]           w_count_nxt;
    logic [c_aw:0]           r_busy_count;

    // Decode all writeback clears into one per-entry hit vector; duplicate
    // clears to the same entry simply OR together
    always_comb begin
        w_clr_hit = '0;
        for (int k = 0; k < NUM_WB_PORTS; k++) begin
            if (clr_en[k]) begin
                w_clr_hit[clr_addr[k*c_aw +: c_aw]] = 1'b1;
            end
        end
    end

    // Next state: clears first, then the set overrides them for its own
    // entry; entry 0 stays ready and flush wipes everything
    always_comb begin
        w_busy_nxt = r_busy & ~w_clr_hit;
        if (set_en) begin
            w_busy_nxt[set_addr] = set_data;
        end
        w_busy_nxt[0] = 1'b0;
        if (flush) begin
            w_busy_nxt = '0;
        end
    end

    // Issue-side lookups see same-cycle clears but not sets or flush
    always_comb begin
        rd_busy = '0;
        for (int j = 0; j < NUM_RD_PORTS; j++) begin
            rd_busy[j] = r_busy[rd_addr[j*c_aw +: c_aw]]
                       & ~w_clr_hit[rd_addr[j*c_aw +: c_aw]];
        end
    end

    // Count is taken from the next-state vector so it lands with the bits
    popcount #(
        .WIDTH   (PHY_RF_DEPTH)
    ) u_popcount (
        .i_vec   (w_busy_nxt),
        .o_count (w_count_nxt)
    );

    // Busy bits and occupancy count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_busy_count <= w_count_nxt;
        end
    end

    assign busy_count = r_busy_count;

endmodule : busy_table

`default_nettype wire

// File: tb/tb_busy_table.sv
//==============================================================================
// Module      : tb_busy_table
// Description : Self-checking bench for busy_table: directed scenarios plus
//               randomized traffic compared against a behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_busy_table;

    localparam int c_depth = 128;
    localparam int c_nwb   = 2;
    localparam int c_nrd   = 2;
    localparam int c_aw    = 7;
    localparam int c_cw    = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   set_en;
    logic [c_aw-1:0]        set_addr;
    logic                   set_data;
    logic [c_nwb-1:0]       clr_en;
    logic [c_nwb*c_aw-1:0]  clr_addr;
    logic [c_nrd*c_aw-1:0]  rd_addr;
    logic [c_nrd-1:0]       rd_busy;
    logic [c_cw-1:0]        busy_count;

    int checks = 0;
    int errors = 0;

    // Reference model: one readiness flag per physical register
    bit m_busy [c_depth];

    always #5 clk = ~clk;

    busy_table #(
        .PHY_RF_DEPTH (c_depth),
        .NUM_WB_PORTS (c_nwb),
        .NUM_RD_PORTS (c_nrd)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .set_en     (set_en),
        .set_addr   (set_addr),
        .set_data   (set_data),
        .clr_en     (clr_en),
        .clr_addr   (clr_addr),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy),
        .busy_count (busy_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < c_depth; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic bit clr_hits(input int a);
        bit hit = 1'b0;
        for (int k = 0; k < c_nwb; k++) begin
            if (clr_en[k] && int'(clr_addr[k*c_aw +: c_aw]) == a) hit = 1'b1;
        end
        return hit;
    endfunction

    task automatic idle();
        rst      = 1'b0;
        flush    = 1'b0;
        set_en   = 1'b0;
        set_addr = '0;
        set_data = 1'b0;
        clr_en   = '0;
        clr_addr = '0;
    endtask

    task automatic set_rd(input int j, input int a);
        rd_addr[j*c_aw +: c_aw] = c_aw'(a);
    endtask

    task automatic set_clr(input int k, input int a);
        clr_en[k] = 1'b1;
        clr_addr[k*c_aw +: c_aw] = c_aw'(a);
    endtask

    // One clock: check outputs against the model, then advance the model
    task automatic step(input bit chk);
        #2;
        if (chk) begin
            for (int j = 0; j < c_nrd; j++) begin
                int a;
                a = int'(rd_addr[j*c_aw +: c_aw]);
                check("rd_busy", 32'(rd_busy[j]), 32'(m_busy[a] && !clr_hits(a)));
            end
            check("busy_count", 32'(busy_count), 32'(model_count()));
        end
        @(posedge clk);
        if (rst || flush) begin
            for (int i = 0; i < c_depth; i++) m_busy[i] = 1'b0;
        end else begin
            for (int i = 1; i < c_depth; i++) begin
                if (set_en && int'(set_addr) == i) m_busy[i] = set_data;
                else if (clr_hits(i))              m_busy[i] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    function automatic int rand_addr();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 15));
        return int'($urandom_range(0, c_depth - 1));
    endfunction

    initial begin
        idle();
        rd_addr = '0;
        for (int i = 0; i < c_depth; i++) m_busy[i] = 1'b0;

        // Reset held two cycles with a set request that must be ignored
        rst = 1'b1; set_en = 1'b1; set_addr = 7'd5; set_data = 1'b1;
        set_rd(0, 5);
        step(1'b0);
        step(1'b1);
        idle();
        #1;
        check("rst_rd5", 32'(rd_busy[0]), 32'd0);
        check("rst_count", 32'(busy_count), 32'd0);
        step(1'b1);

        // Set 7, then wake it up through writeback port 1
        set_rd(0, 7);
        set_en = 1'b1; set_addr = 7'd7; set_data = 1'b1;
        step(1'b1);
        idle();
        #1;
        check("set7_rd", 32'(rd_busy[0]), 32'd1);
        check("set7_count", 32'(busy_count), 32'd1);
        step(1'b1);
        set_clr(1, 7);
        #1;
        check("bypass7", 32'(rd_busy[0]), 32'd0);
        step(1'b1);
        idle();
        #1;
        check("clr7_count", 32'(busy_count), 32'd0);

        // Set/clear collision on 9: set wins
        set_rd(0, 9);
        set_en = 1'b1; set_addr = 7'd9; set_data = 1'b1;
        step(1'b1);
        set_clr(0, 9);
        step(1'b1);
        idle();
        #1;
        check("coll9_rd", 32'(rd_busy[0]), 32'd1);
        check("coll9_count", 32'(busy_count), 32'd1);
        set_clr(0, 9);
        step(1'b1);

        // Register 0 is never busy
        idle();
        set_rd(0, 0);
        set_en = 1'b1; set_addr = 7'd0; set_data = 1'b1;
        step(1'b1);
        idle();
        #1;
        check("reg0_rd", 32'(rd_busy[0]), 32'd0);
        check("reg0_count", 32'(busy_count), 32'd0);

        // Dual clear of 12 drops the count by exactly one
        set_en = 1'b1; set_addr = 7'd12; set_data = 1'b1;
        step(1'b1);
        idle();
        set_clr(0, 12);
        set_clr(1, 12);
        step(1'b1);
        idle();
        #1;
        check("dual12_count", 32'(busy_count), 32'd0);

        // Fill 1..20, then flush with a simultaneous set of 30
        for (int i = 1; i <= 20; i++) begin
            set_en = 1'b1; set_addr = c_aw'(i); set_data = 1'b1;
            step(1'b1);
        end
        idle();
        #1;
        check("pre_flush_count", 32'(busy_count), 32'd20);
        flush = 1'b1; set_en = 1'b1; set_addr = 7'd30; set_data = 1'b1;
        set_rd(0, 30);
        set_rd(1, 1);
        step(1'b1);
        idle();
        #1;
        check("flush_count", 32'(busy_count), 32'd0);
        check("flush_rd30", 32'(rd_busy[0]), 32'd0);
        check("flush_rd1", 32'(rd_busy[1]), 32'd0);

        // Fill every register, then release 64 through the set port
        for (int i = 1; i < c_depth; i++) begin
            set_en = 1'b1; set_addr = c_aw'(i); set_data = 1'b1;
            step(1'b1);
        end
        idle();
        #1;
        check("fill_count", 32'(busy_count), 32'd127);
        set_en = 1'b1; set_addr = 7'd64; set_data = 1'b0;
        step(1'b1);
        idle();
        #1;
        check("release64_count", 32'(busy_count), 32'd126);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            idle();
            rst      = ($urandom_range(0, 255) == 0);
            flush    = ($urandom_range(0, 63) == 0);
            set_en   = ($urandom_range(0, 3) != 0);
            set_addr = c_aw'(rand_addr());
            set_data = ($urandom_range(0, 4) != 0);
            for (int k = 0; k < c_nwb; k++) begin
                if ($urandom_range(0, 2) != 0) set_clr(k, rand_addr());
            end
            for (int j = 0; j < c_nrd; j++) begin
                case ($urandom_range(0, 2))
                    0:       set_rd(j, int'(clr_addr[j*c_aw +: c_aw]));
                    1:       set_rd(j, int'(set_addr));
                    default: set_rd(j, rand_addr());
                endcase
            end
            step(1'b1);
        end
        idle();
        step(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_busy_table

`default_nettype wire
